// File: rtl/ins_pkg.sv
// Shared encodings, field positions and the pure encode/check function
// for the instruction encoder.
package ins_pkg;

  // Instruction classes.
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // ALU sub-operations.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // MOV sub-operations; memory and HALT only use op 00.
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] OP_ZERO = 2'b00;

  // Field bit positions (least significant bit of each field).
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  // Immediate ranges (signed, inclusive).
  localparam int IMM8_MIN = -128;
  localparam int IMM8_MAX = 127;
  localparam int IMM5_MIN = -16;
  localparam int IMM5_MAX = 15;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [1:0]         op;
    logic [2:0]         rn;
    logic [2:0]         rd;
    logic [2:0]         rm;
    logic [1:0]         shift;
    logic signed [15:0] imm;
  } ins_fields_t;

  typedef struct packed {
    logic        legal;
    logic [15:0] word;
  } enc_result_t;

  // Select which fields a format carries, range-check the immediate,
  // then assemble the word with every unused field forced to zero.
  function automatic enc_result_t encode_ins(input ins_fields_t f);
    enc_result_t r;
    logic rn_en, rd_en, sh_en, rm_en, imm8_en, imm5_en, fmt_ok, rng_ok;
    int   imm_i;
    rn_en   = 1'b0;
    rd_en   = 1'b0;
    sh_en   = 1'b0;
    rm_en   = 1'b0;
    imm8_en = 1'b0;
    imm5_en = 1'b0;
    fmt_ok  = 1'b1;
    imm_i   = int'(f.imm);
    case ({f.opcode, f.op})
      {OPC_MOV, MOV_IMM}:  begin rn_en = 1'b1; imm8_en = 1'b1; end
      {OPC_MOV, MOV_REG}:  begin rd_en = 1'b1; sh_en = 1'b1; rm_en = 1'b1; end
      {OPC_ALU, ALU_ADD},
      {OPC_ALU, ALU_AND}:  begin rn_en = 1'b1; rd_en = 1'b1; sh_en = 1'b1; rm_en = 1'b1; end
      {OPC_ALU, ALU_CMP}:  begin rn_en = 1'b1; sh_en = 1'b1; rm_en = 1'b1; end
      {OPC_ALU, ALU_MVN}:  begin rd_en = 1'b1; sh_en = 1'b1; rm_en = 1'b1; end
      {OPC_LDR, OP_ZERO},
      {OPC_STR, OP_ZERO}:  begin rn_en = 1'b1; rd_en = 1'b1; imm5_en = 1'b1; end
      {OPC_HALT, OP_ZERO}: fmt_ok = 1'b1;
      default:             fmt_ok = 1'b0;
    endcase
    rng_ok = 1'b1;
    if (imm8_en && (imm_i < IMM8_MIN || imm_i > IMM8_MAX)) rng_ok = 1'b0;
    if (imm5_en && (imm_i < IMM5_MIN || imm_i > IMM5_MAX)) rng_ok = 1'b0;

    r.word = '0;
    r.word[OPC_LSB +: 3] = f.opcode;
    r.word[OP_LSB  +: 2] = f.op;
    if (rn_en)   r.word[RN_LSB +: 3] = f.rn;
    if (rd_en)   r.word[RD_LSB +: 3] = f.rd;
    if (sh_en)   r.word[SH_LSB +: 2] = f.shift;
    if (rm_en)   r.word[RM_LSB +: 3] = f.rm;
    if (imm8_en) r.word[7:0] = f.imm[7:0];
    if (imm5_en) r.word[4:0] = f.imm[4:0];
    r.legal = fmt_ok & rng_ok;
    return r;
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// Instruction word FIFO: storage, wrapping pointers, occupancy.
// Output word reads as zero whenever the FIFO is empty.
module ins_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign rvalid  = (count != '0);
  assign push_ok = push & ~full;
  assign pop_ok  = rvalid & pop_ready;
  assign rdata   = rvalid ? mem[rptr] : '0;

  // Storage write at the tail; data is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ins_enc.sv
// Instruction encoder and issue buffer: checks and packs field-level
// requests into 16-bit words, queues legal ones, counts illegal ones.
module ins_enc
  import ins_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             f_opcode,
  input  logic [1:0]             f_op,
  input  logic [2:0]             f_rn,
  input  logic [2:0]             f_rd,
  input  logic [2:0]             f_rm,
  input  logic [1:0]             f_shift,
  input  logic [15:0]            f_imm,
  output logic [15:0]            ins,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic                   err,
  output logic [ERRW-1:0]        err_cnt,
  output logic [$clog2(DEPTH):0] count
);

  ins_fields_t fields;
  enc_result_t enc;
  logic        accept;
  logic        full;
  logic        err_p1;

  // Gather the request fields and run the encode/check function.
  always_comb begin
    fields        = '0;
    fields.opcode = f_opcode;
    fields.op     = f_op;
    fields.rn     = f_rn;
    fields.rd     = f_rd;
    fields.rm     = f_rm;
    fields.shift  = f_shift;
    fields.imm    = $signed(f_imm);
    enc           = encode_ins(fields);
  end

  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign err      = err_p1;

  ins_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept & enc.legal),
    .wdata     (enc.word),
    .pop_ready (ins_ready),
    .rdata     (ins),
    .rvalid    (ins_valid),
    .full      (full),
    .count     (count)
  );

  // Accept -> error flag/counter boundary: one-cycle pulse and saturating count.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_p1  <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_p1 <= accept & ~enc.legal;
      if (accept && !enc.legal && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ins_enc.sv
// Scoreboard bench for ins_enc: stimulus queues expected words, a forked
// monitor compares every popped word in order.
module tb_ins_enc;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  f_opcode;
  logic [1:0]  f_op;
  logic [2:0]  f_rn, f_rd, f_rm;
  logic [1:0]  f_shift;
  logic [15:0] f_imm;
  logic [15:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        err;
  logic [7:0]  err_cnt;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  ins_enc #(.DEPTH(4), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .f_opcode(f_opcode), .f_op(f_op), .f_rn(f_rn), .f_rd(f_rd), .f_rm(f_rm),
    .f_shift(f_shift), .f_imm(f_imm), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .err(err), .err_cnt(err_cnt), .count(count)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic set_fields(input logic [2:0] opc, input logic [1:0] op,
                            input logic [2:0] rn, input logic [2:0] rd,
                            input logic [2:0] rm, input logic [1:0] sh, input int imm);
    f_opcode = opc; f_op = op; f_rn = rn; f_rd = rd; f_rm = rm; f_shift = sh;
    f_imm = 16'(imm);
  endtask

  // Present one request, wait (bounded) for in_ready, queue the expected word.
  task automatic send(input logic [2:0] opc, input logic [1:0] op,
                      input logic [2:0] rn, input logic [2:0] rd,
                      input logic [2:0] rm, input logic [1:0] sh, input int imm,
                      input logic legal, input logic [15:0] word);
    int n;
    set_fields(opc, op, rn, rd, rm, sh, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%0b expected=1", in_ready);
    end else if (legal) begin
      exp_q.push_back(word);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ins_ready = 1'b0;
    set_fields(3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 0);

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (ins_valid && ins_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_word actual=%04h expected=none", ins);
            end else begin
              mon_exp = exp_q.pop_front();
              if (ins !== mon_exp) begin
                failures++;
                $display("FAIL word_order actual=%04h expected=%04h", ins, mon_exp);
              end
            end
          end else if (!ins_valid) begin
            checks++;
            if (ins !== 16'h0000) begin
              failures++;
              $display("FAIL ins_idle_zero actual=%04h expected=0000", ins);
            end
          end
        end
      end
    join_none

    // Reset state
    cycles(2);
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_ins_valid", int'(ins_valid), 0);
    chk("rst_ins", int'(ins), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_count", int'(count), 0);

    // MOV imm latency and pop
    ins_ready = 1'b1;
    send(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'd0, -1, 1'b1, 16'hD3FF);
    chk("movimm_valid", int'(ins_valid), 1);
    chk("movimm_word", int'(ins), 16'hD3FF);
    cycles(1);
    chk("movimm_popped_valid", int'(ins_valid), 0);
    chk("movimm_popped_ins", int'(ins), 0);

    // Register formats, unused fields forced to zero
    send(3'b101, 2'b00, 3'd1, 3'd2, 3'd7, 2'b01, 0, 1'b1, 16'hA14F);
    send(3'b101, 2'b01, 3'd5, 3'd6, 3'd4, 2'b00, 0, 1'b1, 16'hAD04);
    send(3'b110, 2'b00, 3'd7, 3'd3, 3'd5, 2'b10, 0, 1'b1, 16'hC075);
    send(3'b101, 2'b10, 3'd4, 3'd5, 3'd6, 2'b11, 0, 1'b1, 16'hB4BE);
    send(3'b101, 2'b11, 3'd3, 3'd1, 3'd2, 2'b00, 0, 1'b1, 16'hB822);
    send(3'b011, 2'b00, 3'd2, 3'd1, 3'd7, 2'b11, -16, 1'b1, 16'h6230);
    send(3'b100, 2'b00, 3'd7, 3'd0, 3'd0, 2'b00, 15, 1'b1, 16'h870F);
    send(3'b111, 2'b00, 3'd7, 3'd7, 3'd7, 2'b11, 99, 1'b1, 16'hE000);
    send(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'd0, -128, 1'b1, 16'hD080);
    cycles(3);

    // Illegal requests
    send(3'b011, 2'b00, 3'd2, 3'd1, 3'd0, 2'd0, 16, 1'b0, 16'h0);
    chk("ldr_range_err", int'(err), 1);
    chk("ldr_range_cnt", int'(err_cnt), 1);
    chk("ldr_range_count", int'(count), 0);
    cycles(1);
    chk("err_one_cycle", int'(err), 0);
    send(3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 0, 1'b0, 16'h0);
    chk("bad_opcode_cnt", int'(err_cnt), 2);
    send(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'd0, 128, 1'b0, 16'h0);
    chk("movimm_range_cnt", int'(err_cnt), 3);
    send(3'b011, 2'b01, 3'd1, 3'd0, 3'd0, 2'd0, 0, 1'b0, 16'h0);
    chk("ldr_bad_op_cnt", int'(err_cnt), 4);
    for (int i = 0; i < 260; i++)
      send(3'b000, 2'(i), 3'd0, 3'd0, 3'd0, 2'd0, 0, 1'b0, 16'h0);
    chk("err_cnt_saturate", int'(err_cnt), 8'hFF);
    chk("illegal_count", int'(count), 0);

    // Full FIFO backpressure
    ins_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(3'b111, 2'b00, 3'(i), 3'd5, 3'd1, 2'd2, i, 1'b1, 16'hE000);
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    set_fields(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 0);
    in_valid = 1'b1;
    cycles(2);
    chk("full_held_count", int'(count), 4);
    ins_ready = 1'b1;
    cycles(1);
    ins_ready = 1'b0;
    chk("after_pop_count", int'(count), 3);
    chk("after_pop_in_ready", int'(in_ready), 1);
    exp_q.push_back(16'hE000);
    cycles(1);
    in_valid = 1'b0;
    chk("fifth_accepted_count", int'(count), 4);
    ins_ready = 1'b1;
    cycles(6);
    chk("drained_count", int'(count), 0);

    // Simultaneous push/pop at count=2 with pointer wrap
    ins_ready = 1'b0;
    send(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'd0, 17, 1'b1, 16'hD011);
    send(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'd0, 34, 1'b1, 16'hD122);
    chk("pp_pre_count", int'(count), 2);
    ins_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_fields(3'b110, 2'b10, 3'(i), 3'd0, 3'd0, 2'd0, i * 3);
      in_valid = 1'b1;
      exp_q.push_back(16'hD000 | 16'((i % 8) << 8) | 16'(i * 3));
      cycles(1);
      chk("pp_count", int'(count), 2);
    end
    in_valid = 1'b0;
    cycles(4);
    chk("pp_drained", int'(count), 0);

    // Mid-operation reset
    ins_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 0, 1'b1, 16'hE000);
    set_fields(3'b001, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 0);
    in_valid = 1'b1;
    cycles(1);
    in_valid = 1'b0;
    chk("pre_rst_err", int'(err), 1);
    chk("pre_rst_count", int'(count), 3);
    reset = 1'b1;
    exp_q.delete();
    cycles(1);
    reset = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(ins_valid), 0);
    chk("mid_rst_ins", int'(ins), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_err_cnt", int'(err_cnt), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);

    // Normal operation after reset
    ins_ready = 1'b1;
    send(3'b101, 2'b00, 3'd6, 3'd5, 3'd4, 2'b10, 0, 1'b1, 16'hA6B4);
    cycles(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
